// File: rtl/cavlc_pkg.sv
// Shared types and constants for the CAVLC residual-block decoder.
package cavlc_pkg;
  localparam int COEFF_W        = 5;
  localparam int SHIFT_W        = 5;
  localparam int TZ_W           = 4;
  localparam int MAX_COEFF_LUMA = 16;
  localparam int MAX_COEFF_AC   = 15;

  typedef enum logic [2:0] {IDLE, CT, LV, TZ, RB, DONE, ERR} seq_state_t;
endpackage

// File: rtl/cavlc_block_sequencer_if.sv
// Stage-side bundle of the block sequencer: enables, done/result handshakes, shift requests.
interface cavlc_block_sequencer_if;
  import cavlc_pkg::*;

  logic               CtEnable;
  logic               CtDone;
  logic [COEFF_W-1:0] CtTotalCoeff;
  logic [1:0]         CtTrailingOnes;
  logic               CtShiftEn;
  logic [SHIFT_W-1:0] CtNumShift;

  logic               LvEnable;
  logic               LvDone;
  logic               LvShiftEn;
  logic [SHIFT_W-1:0] LvNumShift;
  logic [COEFF_W-1:0] TotalCoeff;
  logic [1:0]         TrailingOnes;

  logic               TzEnable;
  logic               TzDone;
  logic [TZ_W-1:0]    TzTotalZeros;
  logic               TzShiftEn;
  logic [SHIFT_W-1:0] TzNumShift;

  logic               RbEnable;
  logic               RbDone;
  logic               RbShiftEn;
  logic [SHIFT_W-1:0] RbNumShift;

  logic               ShiftEn;
  logic [SHIFT_W-1:0] NumShift;

  modport master (
    output CtEnable, LvEnable, TzEnable, RbEnable, TotalCoeff, TrailingOnes, ShiftEn, NumShift,
    input  CtDone, CtTotalCoeff, CtTrailingOnes, CtShiftEn, CtNumShift,
    input  LvDone, LvShiftEn, LvNumShift,
    input  TzDone, TzTotalZeros, TzShiftEn, TzNumShift,
    input  RbDone, RbShiftEn, RbNumShift
  );

  modport slave (
    input  CtEnable, LvEnable, TzEnable, RbEnable, TotalCoeff, TrailingOnes, ShiftEn, NumShift,
    output CtDone, CtTotalCoeff, CtTrailingOnes, CtShiftEn, CtNumShift,
    output LvDone, LvShiftEn, LvNumShift,
    output TzDone, TzTotalZeros, TzShiftEn, TzNumShift,
    output RbDone, RbShiftEn, RbNumShift
  );
endinterface

// File: rtl/cavlc_shift_mux.sv
// Routes the active stage's shift request to the shared bitstream shifter; combinational.
module cavlc_shift_mux
  import cavlc_pkg::*;
(
  input  seq_state_t         State,
  input  logic               CtShiftEn,
  input  logic [SHIFT_W-1:0] CtNumShift,
  input  logic               LvShiftEn,
  input  logic [SHIFT_W-1:0] LvNumShift,
  input  logic               TzShiftEn,
  input  logic [SHIFT_W-1:0] TzNumShift,
  input  logic               RbShiftEn,
  input  logic [SHIFT_W-1:0] RbNumShift,
  output logic               ShiftEn,
  output logic [SHIFT_W-1:0] NumShift
);
  always_comb begin
    ShiftEn  = 1'b0;
    NumShift = '0;
    case (State)
      CT:      begin ShiftEn = CtShiftEn; NumShift = CtNumShift; end
      LV:      begin ShiftEn = LvShiftEn; NumShift = LvNumShift; end
      TZ:      begin ShiftEn = TzShiftEn; NumShift = TzNumShift; end
      RB:      begin ShiftEn = RbShiftEn; NumShift = RbNumShift; end
      default: ;
    endcase
    // The shifter may treat NumShift as live even without ShiftEn, so keep it quiet.
    if (!ShiftEn) NumShift = '0;
  end
endmodule

// File: rtl/cavlc_block_sequencer.sv
// CAVLC residual-block controller: runs coeff_token -> level -> total_zeros -> run_before,
// skipping empty stages and flagging illegal counts. CAVLC_WATCHDOG_EN adds a per-stage stall limit.
module cavlc_block_sequencer
  import cavlc_pkg::*;
#(
  parameter int MAX_COEFF       = MAX_COEFF_LUMA,
  parameter int WATCHDOG_CYCLES = 64,
  parameter int BLK_CNT_W       = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [COEFF_W-1:0]   BlockMaxCoeff,
  output logic                 Busy,
  output logic                 BlockDone,
  output logic                 Error,
  output logic [BLK_CNT_W-1:0] BlocksDecoded,
  cavlc_block_sequencer_if.master Stg
);
  localparam int SUM_W = COEFF_W + 1;

  seq_state_t         state, nextState;
  logic [COEFF_W-1:0] maxCoeff, maxCoeffIn;
  logic [SUM_W-1:0]   tzSum;
  logic               ctIllegal;
  logic               wdExpire;

  assign maxCoeffIn = (BlockMaxCoeff > COEFF_W'(MAX_COEFF)) ? COEFF_W'(MAX_COEFF) : BlockMaxCoeff;
  assign ctIllegal  = (Stg.CtTotalCoeff > maxCoeff) ||
                      ({{(COEFF_W-2){1'b0}}, Stg.CtTrailingOnes} > Stg.CtTotalCoeff);
  // One bit wider than TotalCoeff so a large TotalZeros cannot wrap past the limit.
  assign tzSum = {1'b0, Stg.TotalCoeff} + {{(SUM_W-TZ_W){1'b0}}, Stg.TzTotalZeros};

`ifdef CAVLC_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES);
  logic [WD_W-1:0] stageCnt;

  assign wdExpire = (stageCnt == WD_W'(WATCHDOG_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (Reset || (nextState != state)) stageCnt <= '0;
    else                               stageCnt <= stageCnt + WD_W'(1);
  end
`else
  assign wdExpire = 1'b0;
`endif

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (Start) nextState = CT;
      CT: if (Stg.CtDone) begin
        if (ctIllegal)                       nextState = ERR;
        else if (Stg.CtTotalCoeff == '0)     nextState = DONE;
        else                                 nextState = LV;
      end
      LV: if (Stg.LvDone) nextState = (Stg.TotalCoeff == maxCoeff) ? DONE : TZ;
      TZ: if (Stg.TzDone) begin
        if (tzSum > {1'b0, maxCoeff})                            nextState = ERR;
        else if (Stg.TzTotalZeros == '0 || Stg.TotalCoeff == 1) nextState = DONE;
        else                                                     nextState = RB;
      end
      RB:      if (Stg.RbDone) nextState = DONE;
      default: nextState = IDLE;
    endcase
    // Every Done moves the state, so "no state change" here means the stage is stalled.
    if (wdExpire && (state inside {CT, LV, TZ, RB}) && (nextState == state)) nextState = ERR;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state            <= IDLE;
      maxCoeff         <= '0;
      Busy             <= 1'b0;
      BlockDone        <= 1'b0;
      Error            <= 1'b0;
      BlocksDecoded    <= '0;
      Stg.CtEnable     <= 1'b0;
      Stg.LvEnable     <= 1'b0;
      Stg.TzEnable     <= 1'b0;
      Stg.RbEnable     <= 1'b0;
      Stg.TotalCoeff   <= '0;
      Stg.TrailingOnes <= '0;
    end else begin
      state        <= nextState;
      Busy         <= (nextState != IDLE);
      BlockDone    <= (nextState == DONE);
      Error        <= (nextState == ERR);
      Stg.CtEnable <= (nextState == CT);
      Stg.LvEnable <= (nextState == LV);
      Stg.TzEnable <= (nextState == TZ);
      Stg.RbEnable <= (nextState == RB);
      if (state == IDLE && Start) maxCoeff <= maxCoeffIn;
      if (state == CT && Stg.CtDone) begin
        Stg.TotalCoeff   <= Stg.CtTotalCoeff;
        Stg.TrailingOnes <= Stg.CtTrailingOnes;
      end
      if (nextState == DONE) BlocksDecoded <= BlocksDecoded + BLK_CNT_W'(1);
    end
  end

  cavlc_shift_mux uShiftMux (
    .State      (state),
    .CtShiftEn  (Stg.CtShiftEn),
    .CtNumShift (Stg.CtNumShift),
    .LvShiftEn  (Stg.LvShiftEn),
    .LvNumShift (Stg.LvNumShift),
    .TzShiftEn  (Stg.TzShiftEn),
    .TzNumShift (Stg.TzNumShift),
    .RbShiftEn  (Stg.RbShiftEn),
    .RbNumShift (Stg.RbNumShift),
    .ShiftEn    (Stg.ShiftEn),
    .NumShift   (Stg.NumShift)
  );
endmodule

// File: tb/tb_cavlc_block_sequencer.sv
// Scoreboard bench for cavlc_block_sequencer: blocks queue their expected outcome and stage trace.
module tb_cavlc_block_sequencer;
  import cavlc_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [4:0]  BlockMaxCoeff;
  logic        Busy;
  logic        BlockDone;
  logic        Error;
  logic [15:0] BlocksDecoded;

  cavlc_block_sequencer_if stg();

  cavlc_block_sequencer dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Start         (Start),
    .BlockMaxCoeff (BlockMaxCoeff),
    .Busy          (Busy),
    .BlockDone     (BlockDone),
    .Error         (Error),
    .BlocksDecoded (BlocksDecoded),
    .Stg           (stg)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        err;
    logic [15:0] trace;
  } expBlock_t;

  expBlock_t   sbq[$];
  int          nVectors = 0;
  int          nMiscompares = 0;
  int          expBlocks = 0;
  logic [15:0] monTrace = '0;
  logic [3:0]  monPrevEn = '0;
  logic        monPrevDone = 1'b0;
  logic        monPrevErr = 1'b0;

  task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stage codes in the trace: CT=1, LV=2, TZ=3, RB=4, newest in the low nibble.
  function automatic void model(input logic [4:0] mx, input logic [4:0] tc, input logic [1:0] t1,
                                input logic [3:0] tz, output logic [15:0] tr, output logic err);
    logic [5:0] sum;
    sum = {1'b0, tc} + {2'b00, tz};
    tr  = 16'h0001;
    err = 1'b0;
    if (tc > mx || {3'b000, t1} > tc) err = 1'b1;
    else if (tc != 5'd0) begin
      tr = 16'h0012;
      if (tc != mx) begin
        tr = 16'h0123;
        if (sum > {1'b0, mx})            err = 1'b1;
        else if (tz != 4'd0 && tc != 5'd1) tr = 16'h1234;
      end
    end
  endfunction

  task automatic monitor();
    expBlock_t e;
    if (Reset) begin
      monTrace = '0; monPrevEn = '0; monPrevDone = 1'b0; monPrevErr = 1'b0;
      return;
    end
    if (stg.CtEnable && !monPrevEn[3]) monTrace = {monTrace[11:0], 4'h1};
    if (stg.LvEnable && !monPrevEn[2]) monTrace = {monTrace[11:0], 4'h2};
    if (stg.TzEnable && !monPrevEn[1]) monTrace = {monTrace[11:0], 4'h3};
    if (stg.RbEnable && !monPrevEn[0]) monTrace = {monTrace[11:0], 4'h4};
    if (monPrevDone) expectEq("blockdone_width", 32'(BlockDone), 0);
    if (monPrevErr)  expectEq("error_width", 32'(Error), 0);
    if (BlockDone || Error) begin
      if (sbq.size() == 0) expectEq("unexpected_end", 1, 0);
      else begin
        e = sbq.pop_front();
        expectEq("outcome_error", 32'(Error), 32'(e.err));
        expectEq("outcome_done", 32'(BlockDone), 32'(!e.err));
        expectEq("stage_trace", 32'(monTrace), 32'(e.trace));
        expectEq("busy_at_end", 32'(Busy), 1);
        expectEq("enables_at_end", 32'({stg.CtEnable, stg.LvEnable, stg.TzEnable, stg.RbEnable}), 0);
      end
      monTrace = '0;
    end
    monPrevEn   = {stg.CtEnable, stg.LvEnable, stg.TzEnable, stg.RbEnable};
    monPrevDone = BlockDone;
    monPrevErr  = Error;
  endtask

  always @(negedge Clk) monitor();

  task automatic runBlock(input logic [4:0] mx, input logic [4:0] tc, input logic [1:0] t1,
                          input logic [3:0] tz, input bit stallLv);
    logic [15:0] tr;
    logic        err;
    logic [3:0]  en, prevEn;
    logic        expEn;
    logic [4:0]  expNum;
    int          stCyc, lvCyc;
    bit          pendEnd, finished;
    model(mx, tc, t1, tz, tr, err);
    if (stallLv) begin tr = 16'h0012; err = 1'b1; end
    sbq.push_back('{err: err, trace: tr});

    Start = 1'b1; BlockMaxCoeff = mx;
    @(posedge Clk); #1;
    Start = 1'b0; BlockMaxCoeff = 5'd3;
    expectEq("ct_latency", 32'(stg.CtEnable), 1);

    prevEn = '0; stCyc = 0; lvCyc = 0; pendEnd = 0; finished = 0;
    for (int c = 0; c < 300; c++) begin
      stg.CtDone = 0; stg.LvDone = 0; stg.TzDone = 0; stg.RbDone = 0; Start = 0;
      if (pendEnd) begin
        expectEq("end_latency", 32'(BlockDone | Error), 1);
        pendEnd = 0;
      end
      if (!Busy) begin finished = 1; break; end
      en     = {stg.CtEnable, stg.LvEnable, stg.TzEnable, stg.RbEnable};
      stCyc  = (en == prevEn) ? stCyc + 1 : 0;
      prevEn = en;
      expEn = 1'b0; expNum = 5'd0;
      if (stg.CtEnable)      begin expEn = 1'b1; expNum = 5'd3; end
      else if (stg.LvEnable) begin expEn = 1'b1; expNum = 5'd9; end
      else if (stg.TzEnable) begin expEn = 1'b1; expNum = 5'd4; end
      expectEq("shift_en", 32'(stg.ShiftEn), 32'(expEn));
      expectEq("num_shift", 32'(stg.NumShift), 32'(expNum));
      if (stg.CtEnable && stCyc == 0) stg.LvDone = 1;
      if (stg.CtEnable && stCyc == 1) begin
        stg.CtDone = 1; stg.CtTotalCoeff = tc; stg.CtTrailingOnes = t1; stg.RbDone = 1;
        pendEnd = (tr[3:0] == 4'h1);
      end
      if (stg.LvEnable) lvCyc++;
      if (stg.LvEnable && stCyc == 0) begin
        expectEq("lv_total_coeff", 32'(stg.TotalCoeff), 32'(tc));
        expectEq("lv_trailing_ones", 32'(stg.TrailingOnes), 32'(t1));
      end
      if (stg.LvEnable && stCyc == 1 && !stallLv) begin
        stg.LvDone = 1; pendEnd = (tr[3:0] == 4'h2);
      end
      if (stg.TzEnable && stCyc == 1) begin
        stg.TzDone = 1; stg.TzTotalZeros = tz; pendEnd = (tr[3:0] == 4'h3);
      end
      if (stg.RbEnable && stCyc == 0) Start = 1;
      if (stg.RbEnable && stCyc == 1) begin
        stg.RbDone = 1; pendEnd = 1;
      end
      @(posedge Clk); #1;
    end
    stg.CtDone = 0; stg.LvDone = 0; stg.TzDone = 0; stg.RbDone = 0; Start = 0;
    if (!finished) expectEq("block_timeout", 1, 0);
    if (stallLv) expectEq("watchdog_cycles", 32'(lvCyc), 64);
    if (!err) expBlocks++;
    expectEq("blocks_decoded", 32'(BlocksDecoded), 32'(expBlocks[15:0]));
    @(posedge Clk); #1;
    expectEq("idle_after_block", 32'(Busy), 0);
  endtask

  logic [4:0] tMx [0:10] = '{5'd16, 5'd16, 5'd15, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd15, 5'd16};
  logic [4:0] tTc [0:10] = '{5'd0,  5'd5,  5'd15, 5'd17, 5'd10, 5'd1,  5'd4,  5'd2,  5'd16, 5'd16, 5'd6};
  logic [1:0] tT1 [0:10] = '{2'd0,  2'd2,  2'd3,  2'd0,  2'd1,  2'd1,  2'd3,  2'd3,  2'd0,  2'd0,  2'd0};
  logic [3:0] tTz [0:10] = '{4'd0,  4'd3,  4'd0,  4'd0,  4'd7,  4'd5,  4'd0,  4'd0,  4'd0,  4'd0,  4'd10};

  initial begin
    Reset = 1; Start = 0; BlockMaxCoeff = '0;
    stg.CtDone = 0; stg.CtTotalCoeff = '0; stg.CtTrailingOnes = '0;
    stg.LvDone = 0; stg.TzDone = 0; stg.TzTotalZeros = '0; stg.RbDone = 0;
    stg.CtShiftEn = 1; stg.CtNumShift = 5'd3;
    stg.LvShiftEn = 1; stg.LvNumShift = 5'd9;
    stg.TzShiftEn = 1; stg.TzNumShift = 5'd4;
    stg.RbShiftEn = 0; stg.RbNumShift = 5'd6;
    repeat (2) @(posedge Clk); #1;
    expectEq("reset_outputs", 32'({Busy, BlockDone, Error, stg.CtEnable, stg.LvEnable, stg.TzEnable,
             stg.RbEnable, stg.ShiftEn, stg.NumShift, stg.TotalCoeff, stg.TrailingOnes}), 0);
    expectEq("reset_blocks", 32'(BlocksDecoded), 0);
    Reset = 0;
    @(posedge Clk); #1;

    for (int i = 0; i < 11; i++) runBlock(tMx[i], tTc[i], tT1[i], tTz[i], 1'b0);

    // Reset while the total_zeros stage is active.
    Start = 1; BlockMaxCoeff = 5'(MAX_COEFF_LUMA);
    @(posedge Clk); #1;
    Start = 0; stg.CtDone = 1; stg.CtTotalCoeff = 5'd5; stg.CtTrailingOnes = 2'd1;
    @(posedge Clk); #1;
    stg.CtDone = 0; stg.LvDone = 1;
    @(posedge Clk); #1;
    stg.LvDone = 0;
    expectEq("tz_reached", 32'(stg.TzEnable), 1);
    Reset = 1;
    @(posedge Clk); #1;
    Reset = 0;
    expectEq("midblock_reset_outputs", 32'({Busy, BlockDone, Error, stg.CtEnable, stg.LvEnable,
             stg.TzEnable, stg.RbEnable, stg.ShiftEn, stg.NumShift, stg.TotalCoeff, stg.TrailingOnes}), 0);
    expectEq("midblock_reset_blocks", 32'(BlocksDecoded), 0);
    expBlocks = 0;
    @(posedge Clk); #1;
    expectEq("reset_stays_idle", 32'({Busy, BlockDone, Error}), 0);

    runBlock(5'(MAX_COEFF_LUMA), 5'd5, 2'd2, 4'd3, 1'b0);
    runBlock(5'(MAX_COEFF_AC), 5'd3, 2'd1, 4'd12, 1'b0);
`ifdef CAVLC_WATCHDOG_EN
    runBlock(5'(MAX_COEFF_LUMA), 5'd5, 2'd2, 4'd3, 1'b1);
`endif
    repeat (2) @(posedge Clk); #1;
    expectEq("scoreboard_empty", 32'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end
endmodule
